// File: rtl/fm_pkg.sv
// Shared constants and helpers for the FM modulator and the demodulator NCO path.
// Both ends import this package so they use an identical sine table.
package fm_pkg;

    localparam int PHASE_W    = 32;
    localparam int SAMPLE_W   = 8;
    localparam int LUT_ADDR_W = 6;
    localparam int LUT_DEPTH  = 64;
    localparam int MAG_W      = 7;

    // Quarter-wave sine magnitude: q[k] = round(127*sin(2*pi*(k+0.5)/256)), k = 0..63.
    // The half-step offset makes the folded wave symmetric, so the table never needs
    // an explicit zero or a -128 entry.
    localparam logic [MAG_W-1:0] QUARTER_SINE [LUT_DEPTH] = '{
        7'd2,   7'd5,   7'd8,   7'd11,  7'd14,  7'd17,  7'd20,  7'd23,
        7'd26,  7'd29,  7'd32,  7'd35,  7'd38,  7'd41,  7'd44,  7'd47,
        7'd50,  7'd53,  7'd56,  7'd58,  7'd61,  7'd64,  7'd67,  7'd69,
        7'd72,  7'd74,  7'd77,  7'd79,  7'd82,  7'd84,  7'd86,  7'd89,
        7'd91,  7'd93,  7'd95,  7'd97,  7'd99,  7'd101, 7'd103, 7'd105,
        7'd106, 7'd108, 7'd110, 7'd111, 7'd113, 7'd114, 7'd115, 7'd117,
        7'd118, 7'd119, 7'd120, 7'd121, 7'd122, 7'd123, 7'd124, 7'd124,
        7'd125, 7'd125, 7'd126, 7'd126, 7'd127, 7'd127, 7'd127, 7'd127
    };

    // Instantaneous frequency word: centre step plus the sign-extended sample
    // scaled by 2^shift; the sum wraps modulo 2^32 (negative totals become large steps).
    function automatic logic [PHASE_W-1:0] freq_word(
        input logic [PHASE_W-1:0]  ctrl,
        input logic [SAMPLE_W-1:0] msg,
        input logic [3:0]          shift
    );
        logic [PHASE_W-1:0] dev;
        dev = {{(PHASE_W-SAMPLE_W){msg[SAMPLE_W-1]}}, msg} << shift;
        return ctrl + dev;
    endfunction

endpackage

// File: rtl/fm_sine_lut.sv
// Combinational 8-bit-phase to 8-bit signed sine, built from the quarter-wave
// table with quadrant folding. Output range is -127..+127.
module fm_sine_lut
    import fm_pkg::*;
(
    input  logic [7:0]        phase_i,
    output logic signed [7:0] sine_o
);

    logic [1:0]            quadrant_s;
    logic [LUT_ADDR_W-1:0] idx_s;
    logic [LUT_ADDR_W-1:0] addr_s;
    logic [7:0]            mag_s;

    // Mirror the index in odd quadrants and negate the magnitude in the lower half-wave.
    always_comb begin
        quadrant_s = phase_i[7:6];
        idx_s      = phase_i[LUT_ADDR_W-1:0];
        if (quadrant_s[0]) begin
            addr_s = ~idx_s;
        end else begin
            addr_s = idx_s;
        end
        mag_s = {1'b0, QUARTER_SINE[addr_s]};
        if (quadrant_s[1]) begin
            sine_o = ~mag_s + 8'd1;
        end else begin
            sine_o = mag_s;
        end
    end

endmodule

// File: rtl/fm_modulator.sv
// Numerically controlled FM modulator: held message and configuration set an
// instantaneous frequency word, which steps a 32-bit phase accumulator whose top
// byte addresses the shared sine table. Output is registered.
module fm_modulator
    import fm_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       en,
    input  logic signed [SAMPLE_W-1:0] message,
    input  logic                       msg_valid,
    input  logic [PHASE_W-1:0]         ctr_ctrl,
    input  logic [3:0]                 dev_shift,
    input  logic                       cfg_load,
    output logic [PHASE_W-1:0]         phase,
    output logic signed [SAMPLE_W-1:0] modulated
);

    logic [SAMPLE_W-1:0] msg_q,   msg_d;
    logic [PHASE_W-1:0]  ctrl_q,  ctrl_d;
    logic [3:0]          shift_q, shift_d;
    logic [PHASE_W-1:0]  freq_q,  freq_d;
    logic [PHASE_W-1:0]  phase_q, phase_d;
    logic [SAMPLE_W-1:0] mod_q,   mod_d;
    logic signed [7:0]   sine_s;

    fm_sine_lut u_sine (
        .phase_i (phase_q[PHASE_W-1:PHASE_W-8]),
        .sine_o  (sine_s)
    );

    // Next-state: strobed captures, free-running frequency word, gated accumulator and output.
    always_comb begin
        msg_d   = msg_q;
        ctrl_d  = ctrl_q;
        shift_d = shift_q;
        phase_d = phase_q;
        mod_d   = mod_q;
        if (msg_valid) begin
            msg_d = message;
        end else begin
            msg_d = msg_q;
        end
        if (cfg_load) begin
            ctrl_d  = ctr_ctrl;
            shift_d = dev_shift;
        end else begin
            ctrl_d  = ctrl_q;
            shift_d = shift_q;
        end
        freq_d = freq_word(ctrl_q, msg_q, shift_q);
        if (en) begin
            phase_d = phase_q + freq_q;
            mod_d   = sine_s;
        end else begin
            phase_d = phase_q;
            mod_d   = mod_q;
        end
    end

    // State registers with asynchronous clear of every stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            msg_q   <= '0;
            ctrl_q  <= '0;
            shift_q <= 4'd0;
            freq_q  <= '0;
            phase_q <= '0;
            mod_q   <= '0;
        end else begin
            msg_q   <= msg_d;
            ctrl_q  <= ctrl_d;
            shift_q <= shift_d;
            freq_q  <= freq_d;
            phase_q <= phase_d;
            mod_q   <= mod_d;
        end
    end

    assign phase     = phase_q;
    assign modulated = mod_q;

endmodule

// File: tb/tb_fm_modulator.sv
// Scoreboard bench for fm_modulator: the driver updates a behavioural model each
// cycle and queues the expected outputs; a monitor pops and compares after each edge.
module tb_fm_modulator;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              en;
    logic signed [7:0] message;
    logic              msg_valid;
    logic [31:0]       ctr_ctrl;
    logic [3:0]        dev_shift;
    logic              cfg_load;
    logic [31:0]       phase;
    logic signed [7:0] modulated;

    always #5 clk = ~clk;

    fm_modulator dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .message   (message),
        .msg_valid (msg_valid),
        .ctr_ctrl  (ctr_ctrl),
        .dev_shift (dev_shift),
        .cfg_load  (cfg_load),
        .phase     (phase),
        .modulated (modulated)
    );

    typedef struct packed {
        logic [31:0] ph;
        logic [7:0]  md;
    } exp_t;

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    // behavioural model state
    logic [7:0]  m_msg;
    logic [31:0] m_ctrl;
    logic [3:0]  m_shift;
    logic [31:0] m_freq;
    logic [31:0] m_phase;
    logic [7:0]  m_mod;

    bit          track = 1'b0;
    int          peak_max = -1000;
    int          peak_min = 1000;

    // sine straight from the continuous formula: sample at (p+0.5)/256 of a cycle
    function automatic logic [7:0] ref_sine(input logic [7:0] p);
        real r;
        int  v;
        r = 127.0 * $sin(2.0 * 3.141592653589793 * (real'(p) + 0.5) / 256.0);
        if (r >= 0.0) v = $rtoi(r + 0.5);
        else          v = -$rtoi(-r + 0.5);
        return 8'(v);
    endfunction

    // deviation term as a signed product, reduced modulo 2^32
    function automatic logic [31:0] dev_term(input logic [7:0] m, input logic [3:0] s);
        longint prod;
        prod = longint'($signed(m)) * (longint'(1) << s);
        return prod[31:0];
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, req, $time);
        end
    endtask

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, $signed(act), $signed(req), $time);
        end
    endtask

    task automatic model_clear();
        m_msg = 8'd0; m_ctrl = 32'd0; m_shift = 4'd0;
        m_freq = 32'd0; m_phase = 32'd0; m_mod = 8'd0;
    endtask

    // one clock: drive inputs on the falling edge, advance the model, queue expectation
    task automatic cycle(input bit r, input bit e, input bit mv, input logic [7:0] msg,
                         input bit cl, input logic [31:0] cc, input logic [3:0] ds);
        logic [31:0] nf;
        exp_t        x;
        @(negedge clk);
        rst_n = r; en = e; msg_valid = mv; message = msg;
        cfg_load = cl; ctr_ctrl = cc; dev_shift = ds;
        if (!r) begin
            model_clear();
        end else begin
            nf = m_ctrl + dev_term(m_msg, m_shift);
            if (e) begin
                m_mod   = ref_sine(m_phase[31:24]);
                m_phase = m_phase + m_freq;
            end
            m_freq = nf;
            if (mv) m_msg = msg;
            if (cl) begin
                m_ctrl  = cc;
                m_shift = ds;
            end
        end
        x.ph = m_phase;
        x.md = m_mod;
        exp_q.push_back(x);
    endtask

    task automatic idle(input int n, input bit e);
        for (int i = 0; i < n; i++) cycle(1'b1, e, 1'b0, 8'h00, 1'b0, 32'h0, 4'd0);
    endtask

    // monitor: one expectation per clock edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check32("phase", phase, e.ph);
                check8("modulated", modulated, e.md);
                if (track) begin
                    if (int'(modulated) > peak_max) peak_max = int'(modulated);
                    if (int'(modulated) < peak_min) peak_min = int'(modulated);
                end
            end
        end
    end

    initial begin
        logic [31:0] p1, p2;
        logic [7:0]  mhold;
        exp_t        x;

        rst_n = 1'b0; en = 1'b0; message = 8'h00; msg_valid = 1'b0;
        ctr_ctrl = 32'h0; dev_shift = 4'd0; cfg_load = 1'b0;
        model_clear();
        #1;
        check32("reset_phase", phase, 32'h0);
        check8("reset_mod", modulated, 8'h00);
        cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 32'h0, 4'd0);
        cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 32'h0, 4'd0);

        // pure carrier: one table step per clock, 256-cycle period
        cycle(1'b1, 1'b1, 1'b1, 8'h00, 1'b1, 32'h0100_0000, 4'd0);
        @(posedge clk); #2;
        check8("first_mod_after_reset", modulated, 8'd2);
        track = 1'b1;
        idle(300, 1'b1);
        @(posedge clk); #2;
        track = 1'b0;
        vectors++;
        if (peak_max != 127 || peak_min != -127) begin
            miscompares++;
            $display("FAIL peaks: got max %0d min %0d, expected 127 / -127", peak_max, peak_min);
        end
        cycle(1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 32'h0, 4'd0);
        @(posedge clk); #2; p1 = phase;
        cycle(1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 32'h0, 4'd0);
        @(posedge clk); #2; p2 = phase;
        check32("carrier_step", p2 - p1, 32'h0100_0000);

        // message 0x10 with shift 8 -> 0x0100_1000
        cycle(1'b1, 1'b1, 1'b1, 8'h10, 1'b1, 32'h0100_0000, 4'd8);
        idle(2, 1'b1);
        @(posedge clk); #2; p1 = phase;
        cycle(1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 32'h0, 4'd0);
        @(posedge clk); #2; p2 = phase;
        check32("dev_step", p2 - p1, 32'h0100_1000);
        idle(20, 1'b1);

        // negative total frequency: phase runs backwards
        cycle(1'b1, 1'b1, 1'b1, 8'h80, 1'b1, 32'h0000_0010, 4'd15);
        idle(2, 1'b1);
        @(posedge clk); #2; p1 = phase;
        cycle(1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 32'h0, 4'd0);
        @(posedge clk); #2; p2 = phase;
        check32("neg_step", p2 - p1, 32'hFFC0_0010);
        idle(60, 1'b1);

        // enable low for 10 cycles: everything frozen, resume without skip
        @(posedge clk); #2; p1 = phase; mhold = modulated;
        idle(10, 1'b0);
        @(posedge clk); #2;
        check32("hold_phase", phase, p1);
        check8("hold_mod", modulated, mhold);
        idle(10, 1'b1);

        // asynchronous reset between edges
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check32("async_rst_phase", phase, 32'h0);
        check8("async_rst_mod", modulated, 8'h00);
        model_clear();
        x.ph = 32'h0; x.md = 8'h00;
        exp_q.push_back(x);
        cycle(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 32'h0, 4'd0);
        cycle(1'b1, 1'b1, 1'b1, 8'h40, 1'b1, 32'h0200_0000, 4'd4);
        idle(30, 1'b1);

        // randomized run
        for (int i = 0; i < 600; i++) begin
            cycle(1'b1, ($urandom_range(0, 9) != 0), ($urandom_range(0, 3) == 0), 8'($urandom),
                  ($urandom_range(0, 15) == 0), $urandom, 4'($urandom_range(0, 15)));
        end

        // wrap near the top of the phase circle: reset, carrier of one step, switch to two steps
        cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 32'h0, 4'd0);
        cycle(1'b1, 1'b1, 1'b1, 8'h00, 1'b1, 32'h0100_0000, 4'd0);
        idle(253, 1'b1);
        cycle(1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 32'h0200_0000, 4'd0);
        idle(6, 1'b1);

        repeat (3) @(posedge clk);
        #2;
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fm_modulator.md
FM_MODULATOR -- requirements
Module: fm_modulator

Interface
REQ-001 SHALL: clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL: rst_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL: en  input  1  advance enable; low freezes phase and output.
REQ-004 SHALL: message  input  8  signed two's-complement modulating sample.
REQ-005 SHALL: msg_valid  input  1  single-cycle strobe; captures message.
REQ-006 SHALL: ctr_ctrl  input  32  unsigned centre-frequency control word (phase step per clk).
REQ-007 SHALL: dev_shift  input  4  deviation scale, left-shift amount 0..15 applied to message.
REQ-008 SHALL: cfg_load  input  1  single-cycle strobe; captures ctr_ctrl and dev_shift.
REQ-009 SHALL: phase  output  32  current accumulator phase, unsigned.
REQ-010 SHALL: modulated  output  8  signed two's-complement FM sine output.

Function
REQ-011 SHALL hold message in msg_q, updated at the edge where msg_valid=1 (zero-order hold between strobes).
REQ-012 SHALL hold ctr_ctrl/dev_shift in ctrl_q/shift_q, updated at the edge where cfg_load=1; ports otherwise ignored.
REQ-013 SHALL register freq_q = ctrl_q + (sign-extend-32(msg_q) << shift_q), modulo 2^32, every cycle regardless of en.
REQ-014 SHALL update phase_q = phase_q + freq_q modulo 2^32 at each edge with en=1; wrap through 0 silent; en=0 holds.
REQ-015 SHALL drive phase directly from phase_q.
REQ-016 SHALL register modulated = sine(phase_q[31:24]) at each edge with en=1; en=0 holds.
REQ-017 SHALL compute sine from 64-entry quarter-wave table q[k] = round(127*sin(2*pi*(k+0.5)/256)), k=0..63, 7-bit magnitude.
REQ-018 SHALL index: i=phase_q[29:24] in quadrants 0,2 and ~i in quadrants 1,3 (quadrant = phase_q[31:30]); negate in quadrants 2,3; output range -127..+127, never -128.
REQ-019 SHALL give latency: msg_q change at edge E -> freq_q at E+1 -> phase step changes at E+2 -> modulated reflects it at E+3 (en held high).
REQ-020 SHALL, on simultaneous msg_valid and cfg_load, capture both at the same edge.
REQ-021 SHALL treat negative total frequency (wrap of REQ-013 sum) as large unsigned step; no saturation.

Reset
REQ-022 SHALL asynchronously clear msg_q, ctrl_q, shift_q, freq_q, phase_q, modulated to 0 when rst_n=0, irrespective of clk.
REQ-023 SHALL apply reset mid-operation immediately; first post-reset edge with en=1 gives modulated=+2 (sine of phase 0) and phase=0.

Structure
REQ-024 SHALL place PHASE_W=32, SAMPLE_W=8, LUT_ADDR_W=6, and the quarter-wave table constant in shared package fm_pkg.
REQ-025 SHALL implement table plus quadrant folding as combinational sub-module fm_sine_lut (8-bit phase in, 8-bit signed out); output register stays in fm_modulator.
REQ-026 SHALL share fm_pkg and fm_sine_lut with the demodulator NCO path so both ends use identical sine.

Verification
REQ-027 SHALL cover: reset; cfg_load ctr_ctrl=0x0100_0000, dev_shift=0; message=0; en=1 -> phase steps 0x0100_0000/cycle, modulated period exactly 256 cycles, peaks +127/-127.
REQ-028 SHALL cover: above config, msg_valid with message=0x10, dev_shift=8 -> freq_q=0x0100_1000 one edge after capture; phase step changes two edges after capture.
REQ-029 SHALL cover: ctr_ctrl=0x0000_0010, dev_shift=15, message=0x80 (-128) -> freq_q=0xFFC0_0010, phase decreases each cycle, modulated runs sine backward.
REQ-030 SHALL cover: phase_q=0xFF00_0000, freq_q=0x0200_0000 -> next phase 0x0100_0000 (wrap), modulated=+5 (q[1]).
REQ-031 SHALL cover: en=0 for 10 cycles mid-run -> phase and modulated constant; resume continues from held phase with no skip.
REQ-032 SHALL cover: rst_n asserted between clk edges mid-run -> all outputs 0 immediately; msg_valid and cfg_load in same cycle after release -> both captured.
